// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for the multi-cycle MIPS datapath. A single shared
// ALU/memory is sequenced through fetch, decode, execute, memory and
// writeback steps. Memory states (FETCH, MEMRD, MEMWR) are stretched by the
// MemReady handshake, and a wait counter flags a sticky MemTimeout when a
// memory access takes MEM_WAIT_MAX stalled cycles (0 disables the check).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   Op                  opcode from the instruction register
//   Zero                ALU zero flag (branch resolution)
//   MemReady            memory completes its access this cycle
//   PCEn, IorD, MemRead, MemWrite, IRWrite         memory / PC control
//   RegDst, MemtoReg, RegWrite                     register file control
//   ALUSrcA, ALUSrcB, ALUOp, PCSrc, ExtZero        datapath selects
//   InstrDone           pulse in an instruction's final cycle
//   Illegal             pulse in DECODE for an unsupported opcode
//   MemTimeout          sticky memory timeout flag, cleared by reset
//   State               current FSM state, for debug
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       ExtZero,
    output logic       InstrDone,
    output logic       Illegal,
    output logic       MemTimeout,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [31:0] WAIT_MAX_U = MEM_WAIT_MAX;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       mem_stall;
    logic       logic_imm;

    // andi/ori share the logical-immediate ALU mode and zero-extension.
    assign logic_imm = (Op == OP_ANDI) || (Op == OP_ORI);

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 4'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic. Memory states hold until MemReady; the unused
    // encodings 12-15 fall back to FETCH through the default arm.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_R:                     state_d = S_RTYPEEX;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_FETCH;
                endcase
            end
            // Bit 3 separates sw (101011) from lw (100011).
            S_MEMADR:  state_d = Op[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (MemReady) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (MemReady) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_IMMEX:   state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Wait counter: counts stalled memory cycles, clears whenever the state
    // changes and saturates at 15. The timeout flag latches when the count
    // hits the limit; the FSM itself keeps waiting.
    always_comb begin
        mem_stall  = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR)) && !MemReady;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (state_d != state_q) begin
            wait_cnt_d = 4'd0;
        end else if (mem_stall && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        if ((WAIT_MAX_U != 32'd0) && ({28'd0, wait_cnt_d} == WAIT_MAX_U)) begin
            timeout_d = 1'b1;
        end
    end

    // Output decode. Mostly Moore on state; IRWrite/PCEn in FETCH, InstrDone
    // in MEMWR, PCEn in BRANCH and the IMMEX selects also look at inputs.
    // Every output is held at 0 while reset is asserted.
    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        ExtZero    = 1'b0;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        MemTimeout = 1'b0;
        State      = 4'd0;
        if (!reset) begin
            MemTimeout = timeout_q;
            State      = state_q;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (Op)
                        OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_J: Illegal = 1'b0;
                        default:                        Illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite  = 1'b1;
                    MemtoReg  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite  = 1'b1;
                    IorD      = 1'b1;
                    InstrDone = MemReady;
                end
                S_RTYPEEX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegDst    = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = 2'b01;
                    PCSrc     = 2'b01;
                    InstrDone = 1'b1;
                    // beq (Op[0]=0) taken on Zero, bne (Op[0]=1) on !Zero.
                    PCEn      = Zero ^ Op[0];
                end
                S_IMMEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = logic_imm ? 2'b11 : 2'b00;
                    ExtZero = logic_imm;
                end
                S_IMMWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_JUMP: begin
                    PCSrc     = 2'b10;
                    PCEn      = 1'b1;
                    InstrDone = 1'b1;
                end
                default: begin
                    State = state_q;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It replaces the single-cycle combinational control.
- Sequences one shared ALU/memory through fetch, decode, execute, memory and writeback steps.
- Drives the immediate-extension select: sign-extend for addi/lw/sw/beq/bne, zero-extend for andi/ori.
- Stretches memory states with a ready handshake.

Parameters:
- MEM_WAIT_MAX, 15, max cycles a memory state waits for MemReady before flagging MemTimeout (0 = never time out).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Op  input  6  opcode from instruction register (stable from DECODE to end of instruction)
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes access this cycle
- PCEn  output  1  PC register write enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write-register select: 1 = rd, 0 = rt
- MemtoReg  output  1  writeback data select: 1 = MDR, 0 = ALUOut
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  output  2  ALU B select: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded, 11 logical-imm (decoded from Op)
- PCSrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
- ExtZero  output  1  1 = zero-extend immediate, 0 = sign-extend
- InstrDone  output  1  one-cycle pulse in an instruction's final cycle
- Illegal  output  1  one-cycle pulse on an unsupported opcode
- MemTimeout  output  1  sticky; cleared only by reset
- State  output  4  current state, for debug

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Reset:
  - While reset=1, all outputs are 0, including State and wait counter.
  - On the first edge with reset=1, state becomes FETCH and MemTimeout clears.
  - Reset mid-instruction aborts it. No RegWrite or MemWrite occurs in the reset cycle.
- Outputs are Moore, decoded from state; exceptions noted per state. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCEn=MemReady (Mealy).
  - Hold in FETCH until MemReady=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - lw/sw -> MEMADR
  - R -> RTYPEEX
  - beq/bne -> BRANCH
  - addi/andi/ori -> IMMEX
  - j -> JUMP
  - anything else -> FETCH, with Illegal=1 this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtZero=0. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, InstrDone=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady; then InstrDone=1 (Mealy) and go to FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, RegWrite=1, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, InstrDone=1. PCEn = Zero XOR Op[0] (beq taken on Zero, bne taken on !Zero). Next FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi/ori. ExtZero=1 for andi/ori, 0 for addi. Next IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Next FETCH.
- JUMP: PCSrc=10, PCEn=1, InstrDone=1. Next FETCH.
- Wait counter:
  - 4-bit; counts cycles spent in FETCH/MEMRD/MEMWR with MemReady=0; clears on any state change.
  - If MEM_WAIT_MAX≠0 and the count reaches MEM_WAIT_MAX, MemTimeout sets.
  - The FSM keeps waiting after timeout; no forced exit.
- MemReady=1 in the first cycle of a memory state is legal: zero-wait access, leave after one cycle.
- MemReady outside memory states is ignored.
- Cycle counts at zero wait: lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 2.

Test Plan:
- Reset held 2 cycles mid-MEMWR, then released with MemReady=1 always → MemWrite=0 during reset, State=0 after release, first IRWrite in the cycle after reset deasserts.
- lw (Op=100011), MemReady=1 always → States 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; InstrDone pulses once; next instruction starts cycle 6.
- sw with MemReady low 3 cycles in MEMWR → MemWrite high 4 cycles, IorD=1 throughout, InstrDone coincident with MemReady; MemTimeout stays 0.
- beq Zero=1 → PCEn=1 with PCSrc=01 in BRANCH; bne Zero=1 → PCEn=0; bne Zero=0 → PCEn=1.
- ori (001101) → ExtZero=1 and ALUOp=11 in IMMEX; addi (001000) → ExtZero=0 and ALUOp=00; RegWrite with RegDst=0 in IMMWB.
- Op=111111 → Illegal pulse in DECODE, return to FETCH, no RegWrite/MemWrite; separately MemReady=0 for 15 cycles in FETCH → MemTimeout=1 and sticky until reset.
